// File: rtl/sprite_row_fetcher.sv
// Round-robin row fetcher for the 8x8 1bpp sprite ROM.
// Two renderers share one combinational ROM port; one row word per grant.
module sprite_row_fetcher #(
    parameter int XW = 3,
    parameter int YW = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    input  logic [YW-1:0]      req0_row,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [YW-1:0]      req1_row,
    output logic               req1_ready,
    output logic               resp0_valid,
    output logic               resp1_valid,
    output logic [(1<<XW)-1:0] resp_data,
    output logic [XW+YW-1:0]   o_rom_counter,
    input  logic               i_rom_bit,
    output logic               o_busy
);

    localparam int W = 1 << XW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RESP  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XW-1:0]   col_q, col_d;
    logic [YW-1:0]   row_q, row_d;
    logic            grant_q, grant_d;
    logic            last_grant_q, last_grant_d;
    logic [W-1:0]    data_q, data_d;

    logic            win0;
    logic            win1;

    // On a tie the requester that was not served last wins.
    always_comb begin
        win0 = req0_valid & (~req1_valid | last_grant_q);
        win1 = req1_valid & (~req0_valid | ~last_grant_q);
    end

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        data_d       = data_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;

        unique case (state_q)
            IDLE: begin
                req0_ready = win0;
                req1_ready = win1;
                if (win0) begin
                    row_d        = req0_row;
                    grant_d      = 1'b0;
                    last_grant_d = 1'b0;
                    col_d        = '0;
                    state_d      = FETCH;
                end else if (win1) begin
                    row_d        = req1_row;
                    grant_d      = 1'b1;
                    last_grant_d = 1'b1;
                    col_d        = '0;
                    state_d      = FETCH;
                end
            end
            FETCH: begin
                data_d[col_q] = i_rom_bit;
                col_d         = col_q + XW'(1);
                if (col_q == '1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            data_q       <= data_d;
        end
    end

    always_comb begin
        resp0_valid   = (state_q == RESP) & ~grant_q;
        resp1_valid   = (state_q == RESP) & grant_q;
        resp_data     = data_q;
        o_busy        = (state_q != IDLE);
        o_rom_counter = (state_q == FETCH) ? {row_q, col_q} : '0;
    end

endmodule

// File: tb/tb_sprite_row_fetcher.sv
// Directed bench for sprite_row_fetcher with a behavioural sprite ROM.
module tb_sprite_row_fetcher;

    logic       clk;
    logic       rst_n;
    logic       req0_valid;
    logic [2:0] req0_row;
    logic       req0_ready;
    logic       req1_valid;
    logic [2:0] req1_row;
    logic       req1_ready;
    logic       resp0_valid;
    logic       resp1_valid;
    logic [7:0] resp_data;
    logic [5:0] o_rom_counter;
    logic       i_rom_bit;
    logic       o_busy;

    int total;
    int bad;

    logic [7:0] rom [8];
    logic [7:0] rom_row;

    typedef struct {
        logic       id;
        logic [2:0] row;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [10];

    sprite_row_fetcher #(.XW(3), .YW(3)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req0_valid    (req0_valid),
        .req0_row      (req0_row),
        .req0_ready    (req0_ready),
        .req1_valid    (req1_valid),
        .req1_row      (req1_row),
        .req1_ready    (req1_ready),
        .resp0_valid   (resp0_valid),
        .resp1_valid   (resp1_valid),
        .resp_data     (resp_data),
        .o_rom_counter (o_rom_counter),
        .i_rom_bit     (i_rom_bit),
        .o_busy        (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rom_row   = rom[o_rom_counter[5:3]];
    assign i_rom_bit = rom_row[o_rom_counter[2:0]];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // One isolated request; returns in its RESP cycle.
    task automatic do_req(input logic id, input logic [2:0] row,
                          input logic [7:0] exp);
        @(negedge clk);
        if (id) begin
            req1_valid = 1'b1;
            req1_row   = row;
        end else begin
            req0_valid = 1'b1;
            req0_row   = row;
        end
        #1;
        chk("acc_ready0", {31'd0, req0_ready}, {31'd0, ~id});
        chk("acc_ready1", {31'd0, req1_ready}, {31'd0, id});
        chk("acc_busy", {31'd0, o_busy}, 32'd0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
                req0_row   = ~row;
                req1_row   = ~row;
            end
            #1;
            chk("fetch_addr", {26'd0, o_rom_counter}, {26'd0, row, 3'(c - 1)});
            chk("fetch_busy", {31'd0, o_busy}, 32'd1);
            chk("fetch_nostrobe", {30'd0, resp1_valid, resp0_valid}, 32'd0);
        end
        @(negedge clk);
        #1;
        chk("resp0_v", {31'd0, resp0_valid}, {31'd0, ~id});
        chk("resp1_v", {31'd0, resp1_valid}, {31'd0, id});
        chk("resp_data", {24'd0, resp_data}, {24'd0, exp});
        chk("resp_addr0", {26'd0, o_rom_counter}, 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rom[0] = 8'h70; rom[1] = 8'hF0; rom[2] = 8'h30; rom[3] = 8'h39;
        rom[4] = 8'h3F; rom[5] = 8'h1E; rom[6] = 8'h14; rom[7] = 8'h14;

        tbl[0] = '{1'b0, 3'd3, 8'h39};
        tbl[1] = '{1'b1, 3'd0, 8'h70};
        tbl[2] = '{1'b1, 3'd1, 8'hF0};
        tbl[3] = '{1'b1, 3'd2, 8'h30};
        tbl[4] = '{1'b1, 3'd3, 8'h39};
        tbl[5] = '{1'b1, 3'd4, 8'h3F};
        tbl[6] = '{1'b1, 3'd5, 8'h1E};
        tbl[7] = '{1'b1, 3'd6, 8'h14};
        tbl[8] = '{1'b1, 3'd7, 8'h14};
        tbl[9] = '{1'b0, 3'd5, 8'h1E};

        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_row   = 3'd0;
        req1_row   = 3'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_addr", {26'd0, o_rom_counter}, 32'd0);
        chk("rst_data", {24'd0, resp_data}, 32'd0);
        chk("rst_resp", {30'd0, resp1_valid, resp0_valid}, 32'd0);
        chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_ready", {30'd0, req1_ready, req0_ready}, 32'd0);

        // Tie right after reset: requester 0 first, then 1 with no gap.
        @(negedge clk);
        req0_valid = 1'b1; req0_row = 3'd1;
        req1_valid = 1'b1; req1_row = 3'd4;
        #1;
        chk("tie_ready", {30'd0, req1_ready, req0_ready}, 32'd1);
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            if (c == 11) req1_valid = 1'b0;
            #1;
            if (c <= 8) begin
                chk("tie_wait", {30'd0, req1_ready, req0_ready}, 32'd0);
            end else if (c == 9) begin
                chk("tie_resp0", {30'd0, resp1_valid, resp0_valid}, 32'd1);
                chk("tie_data0", {24'd0, resp_data}, 32'h F0);
                chk("tie_r1_low", {31'd0, req1_ready}, 32'd0);
            end else if (c == 10) begin
                chk("tie_ready1", {30'd0, req1_ready, req0_ready}, 32'd2);
                req0_valid = 1'b0;
            end else if (c <= 18) begin
                chk("tie_addr1", {26'd0, o_rom_counter}, {26'd0, 3'd4, 3'(c - 11)});
            end else begin
                chk("tie_resp1", {30'd0, resp1_valid, resp0_valid}, 32'd2);
                chk("tie_data1", {24'd0, resp_data}, 32'h3F);
            end
        end

        // Both held: grants alternate, one response every 10 cycles.
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 0) begin
                req0_valid = 1'b1; req0_row = 3'd2;
                req1_valid = 1'b1; req1_row = 3'd5;
            end
            if (c == 39) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            #1;
            if (c % 10 == 9) begin
                chk("rr_resp", {30'd0, resp1_valid, resp0_valid},
                    ((c / 10) % 2 == 0) ? 32'd1 : 32'd2);
                chk("rr_data", {24'd0, resp_data},
                    ((c / 10) % 2 == 0) ? 32'h30 : 32'h1E);
            end else if (c % 10 != 0) begin
                chk("rr_quiet", {30'd0, resp1_valid, resp0_valid}, 32'd0);
            end
        end

        // Requester 1 arrives mid-fetch; its row changes after acceptance.
        @(negedge clk);
        req0_valid = 1'b1; req0_row = 3'd6;
        #1;
        chk("busy_acc0", {30'd0, req1_ready, req0_ready}, 32'd1);
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            if (c == 1) req0_valid = 1'b0;
            if (c == 3) begin
                req1_valid = 1'b1;
                req1_row   = 3'd0;
            end
            if (c == 11) begin
                req1_valid = 1'b0;
                req1_row   = 3'd1;
            end
            #1;
            if (c >= 3 && c <= 9) begin
                chk("busy_r1_low", {31'd0, req1_ready}, 32'd0);
            end
            if (c == 9) begin
                chk("busy_resp0", {30'd0, resp1_valid, resp0_valid}, 32'd1);
                chk("busy_data0", {24'd0, resp_data}, 32'h14);
            end
            if (c == 10) begin
                chk("busy_acc1", {31'd0, req1_ready}, 32'd1);
                chk("busy_idle", {31'd0, o_busy}, 32'd0);
            end
            if (c == 19) begin
                chk("busy_resp1", {30'd0, resp1_valid, resp0_valid}, 32'd2);
                chk("busy_data1", {24'd0, resp_data}, 32'h70);
            end
        end

        // Table: full row sweep by requester 1 plus a few requester-0 rows.
        for (int i = 0; i < 10; i++) begin
            do_req(tbl[i].id, tbl[i].row, tbl[i].exp);
        end

        // Reset in the middle of a fetch.
        @(negedge clk);
        req0_valid = 1'b1; req0_row = 3'd3;
        #1;
        chk("rf_acc", {31'd0, req0_ready}, 32'd1);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            req0_valid = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rf_busy", {31'd0, o_busy}, 32'd0);
        chk("rf_addr", {26'd0, o_rom_counter}, 32'd0);
        chk("rf_data", {24'd0, resp_data}, 32'd0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            chk("rf_nostrobe", {29'd0, o_busy, resp1_valid, resp0_valid}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_row = 3'd4;
        req1_valid = 1'b1; req1_row = 3'd2;
        #1;
        chk("rf_tie", {30'd0, req1_ready, req0_ready}, 32'd1);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            #1;
        end
        chk("rf_resp0", {30'd0, resp1_valid, resp0_valid}, 32'd1);
        chk("rf_data0", {24'd0, resp_data}, 32'h3F);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sprite_row_fetcher.md
# sprite_row_fetcher

Arbitrated row-fetch controller for the 8x8 one-bit-per-pixel sprite ROM. Two renderers (player and obstacle) share the single ROM port. The block grants one requester at a time using round-robin, then sequences the ROM address across the eight columns of the requested row. It assembles the bits into a row word and returns that word to the granted requester with a one-cycle response strobe. It sits between the renderers and the sprite ROM, which is a combinational lookup: the ROM colour bit is valid in the same cycle as its address.

## Interface
Parameters:
- XW, default 3: column index width; the row word is 2**XW bits wide.
- YW, default 3: row index width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 requests a row.
- req0_row  in  YW  row index for requester 0; sampled on acceptance.
- req0_ready  out  1  requester 0 accepted this cycle.
- req1_valid  in  1  requester 1 requests a row.
- req1_row  in  YW  row index for requester 1; sampled on acceptance.
- req1_ready  out  1  requester 1 accepted this cycle.
- resp0_valid  out  1  one-cycle strobe: resp_data holds requester 0's row.
- resp1_valid  out  1  one-cycle strobe: resp_data holds requester 1's row.
- resp_data  out  2**XW  fetched row word; bit x = ROM bit at column x.
- o_rom_counter  out  XW+YW  ROM address, {row, col}.
- i_rom_bit  in  1  ROM colour bit for o_rom_counter (combinational).
- o_busy  out  1  high in FETCH and RESP.

## Operation
- FSM states: IDLE, FETCH, RESP.
- IDLE:
  - reqN_ready is combinational: it is high for the arbitration winner only, and only while in IDLE.
  - A transfer occurs when valid and ready are both high.
  - On transfer: latch row, latch grant id, clear col to 0, move to FETCH.
- Arbitration:
  - If only one valid is high, that requester wins.
  - If both are high, the winner is the requester that is not last_grant.
  - last_grant updates on each transfer.
- FETCH:
  - o_rom_counter = {row, col}.
  - Each cycle, resp_data[col] <= i_rom_bit and col increments.
  - When col = 2**XW-1, write the final bit and move to RESP; col wraps to 0.
- RESP:
  - resp<grant>_valid is high for exactly one cycle; resp_data holds the complete word.
  - Move to IDLE next cycle.
- o_rom_counter is 0 in IDLE and RESP.
- reqN_ready is never high outside IDLE, so requests made while busy wait; valid must stay asserted until ready.
- A requester that drops valid before ready is simply not served.
- reqN_row is not sampled after acceptance; changes during FETCH have no effect.
- resp_data is meaningful only while respN_valid is high. Between responses it holds its last value, partially overwritten during FETCH.
- Reset values:
  - state IDLE; col 0; row 0; grant 0; last_grant 1, so requester 0 wins the first tie.
  - resp_data 0, resp0_valid 0, resp1_valid 0, o_rom_counter 0, o_busy 0.
  - req0_ready and req1_ready are 0 unless a valid is already high after reset deasserts.
- Reset mid-FETCH or mid-RESP aborts the transaction: no response strobe, and all registers return to reset values immediately.

## Timing
- Accept at edge A (valid & ready in cycle A).
- Cycles A+1 .. A+2**XW: FETCH, with o_rom_counter col = 0 .. 2**XW-1.
- Cycle A+2**XW+1: RESP, strobe high. For default parameters this is cycle A+9.
- Cycle A+2**XW+2: IDLE; the next request can be accepted in this same cycle.
- Minimum request period is 2**XW+2 cycles (10 at default parameters).
- A pending request from the other requester is accepted in the first IDLE cycle after RESP. This gives back-to-back service with no idle gap.
- o_busy is registered-state decoded; it is high from A+1 through the RESP cycle inclusive.

## Test plan
Bench ROM rows 0..7 = 0x70, 0xF0, 0x30, 0x39, 0x3F, 0x1E, 0x14, 0x14.
- Single request: req0_valid=1, req0_row=3 → req0_ready in cycle 0; o_rom_counter steps 24..31 over cycles 1..8; resp0_valid in cycle 9 with resp_data=0x39; resp1_valid stays 0.
- Simultaneous requests after reset: req0 row 1, req1 row 4, held → req0 granted first (resp_data 0xF0 at cycle 9); req1 accepted at cycle 10 (resp_data 0x3F at cycle 19).
- Round-robin fairness: both requesters hold valid for 4 transactions → grants alternate 0,1,0,1; each response arrives exactly 10 cycles after the previous one.
- Request during busy: req1 raised at cycle 3 of req0's FETCH → req1_ready stays low until the IDLE cycle after resp0_valid; req1_row changes during its own FETCH do not affect its resp_data.
- Full sweep: rows 0..7 requested sequentially by req1 → every resp_data matches the table; o_rom_counter covers 0..63 with no skips.
- Reset mid-fetch: assert rst_n=0 at cycle 5 of FETCH → o_busy=0 and o_rom_counter=0 immediately; no respN_valid pulse; after release, requester 0 wins a tie.
